// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types for the data memory controller: the controller FSM state
// encoding and the request opcode values carried on ReqWrite.
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic kMEM_LD = 1'b0;
    localparam logic kMEM_ST = 1'b1;

endpackage

// File: rtl/data_mem_ctrl_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
// Single-port synchronous RAM, W bits x 2**A words, no reset on contents.
// Ports:
//   i_clk    clock, rising edge
//   i_we     write enable: mem[i_addr] <= i_wdata
//   i_addr   word address (used for both read and write)
//   i_wdata  write data
//   o_rdata  registered read data: mem[i_addr] as seen at the previous edge
// ---------------------------------------------------------------------------
module data_mem_array #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [A-1:0] i_addr,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [2**A];
    logic [W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Load/store responder for the datapath memory port. Accepts one request at a
// time in IDLE, waits LAT cycles in BUSY, then commits a store (StoreDone
// pulse) or returns load data plus destination tag through a valid/ready
// response held in RESP.
// Ports:
//   Clk, ResetN              clock (rising), asynchronous active-low reset
//   ReqValid/ReqReady        request handshake (ReqReady high only in IDLE)
//   ReqWrite                 1 = store, 0 = load
//   ReqAddr/ReqWData/ReqTag  word address, store data, load destination tag
//   RespValid/RespReady      load response handshake
//   RespData/RespTag         load data and echoed tag (registered)
//   StoreDone                one-cycle pulse after a store commits
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int W     = 8,
    parameter int A     = 8,
    parameter int TAG_W = 4,
    parameter int LAT   = 2
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic [A-1:0]     ReqAddr,
    input  logic [W-1:0]     ReqWData,
    input  logic [TAG_W-1:0] ReqTag,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [W-1:0]     RespData,
    output logic [TAG_W-1:0] RespTag,
    output logic             StoreDone
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_write;
    logic [A-1:0]       r_addr;
    logic [W-1:0]       r_wdata;
    logic [TAG_W-1:0]   r_tag;
    logic [W-1:0]       r_resp_data;
    logic [TAG_W-1:0]   r_resp_tag;
    logic               r_store_done;

    logic               w_accept;
    logic               w_commit;
    logic               w_we;
    logic [A-1:0]       w_arr_addr;
    logic [W-1:0]       w_rdata;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ReqReady    = 1'b0;
        RespValid   = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                ReqReady = ResetN;
                if (ReqValid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = (r_write == kMEM_ST) ? IDLE : RESP;
                end
            end
            RESP: begin
                RespValid = 1'b1;
                if (RespReady) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_we = w_commit && (r_write == kMEM_ST);

    // The RAM read is registered, so the array is addressed straight from the
    // request port while IDLE: the accepting edge already fetches the word,
    // and BUSY keeps re-reading the latched address. rdata is therefore valid
    // by the commit cycle even when LAT is 1.
    assign w_arr_addr = (r_state == IDLE) ? ReqAddr : r_addr;

    data_mem_array #(
        .W (W),
        .A (A)
    ) u_array (
        .i_clk   (Clk),
        .i_we    (w_we),
        .i_addr  (w_arr_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_tag        <= '0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
            r_store_done <= 1'b0;
        end else begin
            r_store_done <= w_we;
            if (w_accept) begin
                r_write <= ReqWrite;
                r_addr  <= ReqAddr;
                r_wdata <= ReqWData;
                r_tag   <= ReqTag;
                r_cnt   <= CW'(LAT - 1);
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit && (r_write == kMEM_LD)) begin
                r_resp_data <= w_rdata;
                r_resp_tag  <= r_tag;
            end
        end
    end

    assign RespData  = r_resp_data;
    assign RespTag   = r_resp_tag;
    assign StoreDone = r_store_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Two controllers share clock and reset: u_lat2 (LAT=2) and u_lat1 (LAT=1).
// A timestamp-based reference model predicts every output each cycle; the
// directed sequences add literal expectations on latency, data and tags.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rv    [2];
    logic       rw    [2];
    logic [7:0] ra    [2];
    logic [7:0] rd    [2];
    logic [3:0] rt    [2];
    logic       respr [2];
    logic       rdy   [2];
    logic       vld   [2];
    logic       sd    [2];
    logic [7:0] dout  [2];
    logic [3:0] tout  [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit cmp_en = 0;

    data_mem_ctrl #(.W(8), .A(8), .TAG_W(4), .LAT(2)) u_lat2 (
        .Clk(clk), .ResetN(rst_n),
        .ReqValid(rv[0]), .ReqReady(rdy[0]), .ReqWrite(rw[0]),
        .ReqAddr(ra[0]), .ReqWData(rd[0]), .ReqTag(rt[0]),
        .RespValid(vld[0]), .RespReady(respr[0]),
        .RespData(dout[0]), .RespTag(tout[0]), .StoreDone(sd[0])
    );

    data_mem_ctrl #(.W(8), .A(8), .TAG_W(4), .LAT(1)) u_lat1 (
        .Clk(clk), .ResetN(rst_n),
        .ReqValid(rv[1]), .ReqReady(rdy[1]), .ReqWrite(rw[1]),
        .ReqAddr(ra[1]), .ReqWData(rd[1]), .ReqTag(rt[1]),
        .RespValid(vld[1]), .RespReady(respr[1]),
        .RespData(dout[1]), .RespTag(tout[1]), .StoreDone(sd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A request accepted at the edge ending cycle N commits at the edge
    // ending cycle N+LAT; the memory is a plain array with a written flag.
    int         lat   [2] = '{2, 1};
    bit         mb    [2];
    bit         mr    [2];
    bit         msd   [2];
    bit         mdunk [2];
    bit         mw    [2];
    int         mdone [2];
    logic [7:0] ma    [2];
    logic [7:0] mwd   [2];
    logic [3:0] mtg   [2];
    logic [7:0] md    [2];
    logic [3:0] mt    [2];
    logic [7:0] mmem  [2][256];
    bit         mkn   [2][256];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mb[i] = 0; mr[i] = 0; msd[i] = 0; mdunk[i] = 0;
                md[i] = 8'h00; mt[i] = 4'h0;
            end else begin
                msd[i] = 0;
                if (mr[i]) begin
                    if (respr[i]) mr[i] = 0;
                end else if (mb[i]) begin
                    if (cyc == mdone[i]) begin
                        mb[i] = 0;
                        if (mw[i]) begin
                            mmem[i][ma[i]] = mwd[i];
                            mkn[i][ma[i]]  = 1;
                            msd[i]         = 1;
                        end else begin
                            mr[i]    = 1;
                            md[i]    = mmem[i][ma[i]];
                            mdunk[i] = !mkn[i][ma[i]];
                            mt[i]    = mtg[i];
                        end
                    end
                end else if (rv[i]) begin
                    mb[i]    = 1;
                    mdone[i] = cyc + lat[i];
                    mw[i]    = rw[i];
                    ma[i]    = ra[i];
                    mwd[i]   = rd[i];
                    mtg[i]   = rt[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_ReqReady", i),  32'(rdy[i]), 32'(rst_n && !mb[i] && !mr[i]));
                chk($sformatf("m%0d_RespValid", i), 32'(vld[i]), 32'(mr[i]));
                chk($sformatf("m%0d_StoreDone", i), 32'(sd[i]),  32'(msd[i]));
                chk($sformatf("m%0d_RespTag", i),   32'(tout[i]), 32'(mt[i]));
                if (!mdunk[i])
                    chk($sformatf("m%0d_RespData", i), 32'(dout[i]), 32'(md[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [3:0] t, output int acc);
        int k = 0;
        rv[i] = 1'b1; rw[i] = wr; ra[i] = a; rd[i] = d; rt[i] = t;
        while (!rdy[i] && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("req_accept_timeout", 32'(k), 32'd0);
        acc = cyc;
        tick();
        rv[i] = 1'b0;
    endtask

    task automatic wait_sd(input int i, output int at);
        int k = 0;
        while (!sd[i] && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("storedone_timeout", 32'(k), 32'd0);
        at = cyc;
    endtask

    task automatic wait_v(input int i, output int at);
        int k = 0;
        while (!vld[i] && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("respvalid_timeout", 32'(k), 32'd0);
        at = cyc;
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        int n, m, at, a1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; rw[i] = 0; ra[i] = '0; rd[i] = '0; rt[i] = '0; respr[i] = 1;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick();
        chk("reset_ReqReady_low", 32'(rdy[0]), 32'd0);
        chk("reset_RespData", 32'(dout[0]), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: reset in the middle of a store discards it
        issue(0, 1'b1, 8'h10, 8'hAA, 4'h0, n);
        rst_n = 1'b0;
        tick();
        chk("t1_ReqReady_in_reset", 32'(rdy[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t1_ReqReady_after", 32'(rdy[0]), 32'd1);
        chk("t1_RespValid_after", 32'(vld[0]), 32'd0);
        issue(0, 1'b0, 8'h10, 8'h00, 4'h2, m);
        wait_v(0, at);
        chk("t1_load_not_AA", 32'(dout[0] != 8'hAA), 32'd1);
        tick();

        // 2: store then load, LAT=2
        issue(0, 1'b1, 8'h03, 8'h5C, 4'h0, n);
        wait_sd(0, at);
        chk("t2_StoreDone_cycle", 32'(at - n), 32'd3);
        tick();
        issue(0, 1'b0, 8'h03, 8'h00, 4'd7, m);
        wait_v(0, at);
        chk("t2_RespValid_cycle", 32'(at - m), 32'd3);
        chk("t2_RespData", 32'(dout[0]), 32'h5C);
        chk("t2_RespTag", 32'(tout[0]), 32'd7);
        tick();
        chk("t2_ReqReady_after_resp", 32'(rdy[0]), 32'd1);

        // 3: backpressure on a load from the top address
        issue(0, 1'b1, 8'hFF, 8'h81, 4'h0, n);
        wait_sd(0, at);
        respr[0] = 1'b0;
        issue(0, 1'b0, 8'hFF, 8'h00, 4'd3, m);
        wait_v(0, at);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_RespValid", 32'(vld[0]), 32'd1);
            chk("t3_hold_RespData", 32'(dout[0]), 32'h81);
            chk("t3_hold_RespTag", 32'(tout[0]), 32'd3);
            chk("t3_hold_ReqReady", 32'(rdy[0]), 32'd0);
            tick();
        end
        respr[0] = 1'b1;
        tick();
        chk("t3_ReqReady_released", 32'(rdy[0]), 32'd1);
        chk("t3_RespValid_released", 32'(vld[0]), 32'd0);

        // 4: ReqValid held while busy with a changing address
        issue(0, 1'b1, 8'h20, 8'h11, 4'h0, n);
        wait_sd(0, at);
        issue(0, 1'b1, 8'h21, 8'h22, 4'h0, n);
        wait_sd(0, at);
        tick();
        respr[0] = 1'b0;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 8'h20; rt[0] = 4'd1;
        tick();
        for (int k = 0; k < 6; k++) begin
            ra[0] = 8'h21 + 8'(k);
            rt[0] = 4'(k + 2);
            tick();
        end
        chk("t4_RespValid", 32'(vld[0]), 32'd1);
        chk("t4_RespData_first", 32'(dout[0]), 32'h11);
        chk("t4_RespTag_first", 32'(tout[0]), 32'd1);
        rv[0] = 1'b0;
        respr[0] = 1'b1;
        tick();
        chk("t4_ReqReady_after", 32'(rdy[0]), 32'd1);

        // 5: LAT=1 back-to-back stores and loads, both address extremes
        issue(1, 1'b1, 8'h00, 8'hA1, 4'h0, a1);
        issue(1, 1'b1, 8'h01, 8'hB2, 4'h0, n);
        chk("t5_store_cadence", 32'(n - a1), 32'd2);
        issue(1, 1'b1, 8'hFF, 8'hC3, 4'h0, n);
        issue(1, 1'b0, 8'h00, 8'h00, 4'd4, m);
        chk("t5_store_load_cadence", 32'(m - n), 32'd2);
        wait_v(1, at);
        chk("t5_lat1_latency", 32'(at - m), 32'd2);
        chk("t5_RespData_00", 32'(dout[1]), 32'hA1);
        chk("t5_RespTag_00", 32'(tout[1]), 32'd4);
        tick();
        issue(1, 1'b0, 8'h01, 8'h00, 4'd5, m);
        wait_v(1, at);
        chk("t5_RespData_01", 32'(dout[1]), 32'hB2);
        tick();
        issue(1, 1'b0, 8'hFF, 8'h00, 4'd6, m);
        wait_v(1, at);
        chk("t5_RespData_FF", 32'(dout[1]), 32'hC3);
        chk("t5_RespTag_FF", 32'(tout[1]), 32'd6);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
